// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: size codes, FSM encodings,
// MMIO base default and byte-lane helpers.
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));
  endfunction

  // Little-endian lane enables for an aligned access of the given size.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    return 4'b0001 << offset;
      SZ_H:    return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load extractor: selects the addressed byte/half of a memory
// word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    result   = word;
    case (size)
      SZ_B:    result = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack transaction to data memory with alignment checks,
// timeout abort and load extraction. Define MMIO_EN to route addr >= IO_BASE to io_*.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
`ifdef MMIO_EN
  ,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
`ifdef MMIO_EN
  ,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [3:0]  io_be,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [1:0]       state;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             is_store_q;
  logic             rw_both_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_q;
  logic             we_q;
  logic [31:0]      bus_addr_q;
  logic [3:0]       be_q;
  logic [31:0]      lanes_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             ack;
  logic [31:0]      rd_word;
  logic [31:0]      aligned;
  logic             bad_access;

  assign bad_access = rw_both_q || (size_q == SZ_RSV) || is_misaligned(size_q, addr_q[1:0]);

`ifdef MMIO_EN
  logic io_sel_q;

  assign ack        = io_sel_q ? io_ack : dmem_ack;
  assign rd_word    = io_sel_q ? io_rdata : dmem_rdata;
  assign dmem_req   = req_q & ~io_sel_q;
  assign dmem_we    = we_q & ~io_sel_q;
  assign io_req     = req_q & io_sel_q;
  assign io_we      = we_q & io_sel_q;
  assign io_addr    = bus_addr_q;
  assign io_be      = be_q;
  assign io_wdata   = lanes_q;

  always_ff @(posedge clock) begin
    if (reset)
      io_sel_q <= 1'b0;
    else if (state == ST_CHECK)
      io_sel_q <= (addr_q >= IO_BASE);
  end
`else
  assign ack        = dmem_ack;
  assign rd_word    = dmem_rdata;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
`endif

  assign dmem_addr  = bus_addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = lanes_q;
  assign busy       = (state == ST_CHECK) || (state == ST_WAIT);
  assign done       = (state == ST_DONE);
  assign rdata      = rdata_q;
  assign err        = err_q;

  load_align u_load_align (
    .word        (rd_word),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .ld_unsigned (uns_q),
    .result      (aligned)
  );

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      is_store_q <= 1'b0;
      rw_both_q  <= 1'b0;
      wait_cnt   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      bus_addr_q <= '0;
      be_q       <= '0;
      lanes_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_in && (mem_read || mem_write)) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            size_q     <= size;
            uns_q      <= ld_unsigned;
            is_store_q <= mem_write & ~mem_read;
            rw_both_q  <= mem_read & mem_write;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bad_access) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= ST_DONE;
          end else begin
            req_q      <= 1'b1;
            we_q       <= is_store_q;
            bus_addr_q <= {addr_q[31:2], 2'b00};
            be_q       <= byte_enables(size_q, addr_q[1:0]);
            lanes_q    <= lane_data(size_q, wdata_q);
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= is_store_q ? 32'h0 : aligned;
            err_q   <= 1'b0;
            state   <= ST_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Abort: the request has been held for TIMEOUT_CYC cycles with no ack.
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed accesses push expected
// rdata/err; a negedge monitor pops and compares on every done pulse.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
`ifdef MMIO_EN
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;
`endif

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  mem_access_stage #(.TIMEOUT_CYC(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid_in    (valid_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata)
`ifdef MMIO_EN
    ,
    .io_req      (io_req),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_be       (io_be),
    .io_wdata    (io_wdata),
    .io_ack      (io_ack),
    .io_rdata    (io_rdata)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, {31'b0, err}, {31'b0, mon_e.err});
      end
    end
  end

  // Presents one access, answers the request on its ack_at-th request cycle
  // (0 = never), and checks bus fields, latency and request duration.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rword,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_lanes,
                            input int exp_done_cyc, input int exp_req_cyc);
    int cyc = 0;
    int req_cyc = 0;
    int done_cyc = 0;
    sb.push_back('{name, exp_rdata, exp_err});
    valid_in = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    ld_unsigned = uns; addr = a; wdata = wd;
    while (done_cyc == 0 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
      if (cyc == 1) check({name, "_busy_c1"}, {31'b0, busy}, 32'd1);
      if (done) begin
        done_cyc = cyc;
        check({name, "_busy_done"}, {31'b0, busy}, 32'd0);
      end else if (dmem_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          check({name, "_addr"}, dmem_addr, exp_addr);
          check({name, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
          check({name, "_we"}, {31'b0, dmem_we}, {31'b0, wr & ~rd});
          if (wr) check({name, "_lanes"}, dmem_wdata, exp_lanes);
        end
        if (req_cyc == ack_at) begin
          dmem_ack = 1'b1;
          dmem_rdata = rword;
        end
      end
    end
    check({name, "_latency"}, done_cyc, exp_done_cyc);
    check({name, "_req_cycles"}, req_cyc, exp_req_cyc);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'b00; ld_unsigned = 1'b0; addr = '0; wdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
`ifdef MMIO_EN
    io_ack = 1'b0; io_rdata = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_we", {31'b0, dmem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be", {28'b0, dmem_be}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    //          name      rd wr size   uns addr          wdata         ack rword         exp_rdata     err  addr     be       lanes         done req
    run_access("sw",      0, 1, 2'b10, 0, 32'h10,      32'hDEADBEEF, 1, 32'h0,       32'h0,        0,   32'h10,  4'b1111, 32'hDEADBEEF, 3,   1);
    run_access("lb",      1, 0, 2'b00, 0, 32'h13,      32'h0,        1, 32'h80FF0000, 32'hFFFFFF80, 0,  32'h10,  4'b1000, 32'h0,        3,   1);
    run_access("lbu",     1, 0, 2'b00, 1, 32'h13,      32'h0,        1, 32'h80FF0000, 32'h00000080, 0,  32'h10,  4'b1000, 32'h0,        3,   1);
    run_access("lh",      1, 0, 2'b01, 0, 32'h12,      32'h0,        1, 32'h80FF0000, 32'hFFFF80FF, 0,  32'h10,  4'b1100, 32'h0,        3,   1);
    run_access("lhu",     1, 0, 2'b01, 1, 32'h10,      32'h0,        1, 32'h80FF8001, 32'h00008001, 0,  32'h10,  4'b0011, 32'h0,        3,   1);
    run_access("sb",      0, 1, 2'b00, 0, 32'h21,      32'h000000A5, 1, 32'h0,       32'h0,        0,   32'h20,  4'b0010, 32'hA5A5A5A5, 3,   1);
    run_access("sh",      0, 1, 2'b01, 0, 32'h22,      32'hFFFF1234, 1, 32'h0,       32'h0,        0,   32'h20,  4'b1100, 32'h12341234, 3,   1);
    run_access("lh_mis",  1, 0, 2'b01, 0, 32'h11,      32'h0,        1, 32'h0,       32'h0,        1,   32'h0,   4'b0000, 32'h0,        2,   0);
    run_access("lw_mis",  1, 0, 2'b10, 0, 32'h06,      32'h0,        1, 32'h0,       32'h0,        1,   32'h0,   4'b0000, 32'h0,        2,   0);
    run_access("sz_rsv",  1, 0, 2'b11, 0, 32'h20,      32'h0,        1, 32'h0,       32'h0,        1,   32'h0,   4'b0000, 32'h0,        2,   0);
    run_access("rw_both", 1, 1, 2'b10, 0, 32'h20,      32'h0,        1, 32'h0,       32'h0,        1,   32'h0,   4'b0000, 32'h0,        2,   0);
    run_access("lw_late", 1, 0, 2'b10, 0, 32'h40,      32'h0,        3, 32'h12345678, 32'h12345678, 0,  32'h40,  4'b1111, 32'h0,        5,   3);
    run_access("lw_tmo",  1, 0, 2'b10, 0, 32'h44,      32'h0,        0, 32'h0,       32'h0,        1,   32'h44,  4'b1111, 32'h0,        18,  16);

    // Reset while waiting on memory: request drops, late ack is ignored.
    valid_in = 1'b1; mem_read = 1'b1; size = 2'b10; addr = 32'h80;
    @(posedge clock); #1;
    valid_in = 1'b0; mem_read = 1'b0;
    @(posedge clock); #1;
    check("rstw_req_before", {31'b0, dmem_req}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rstw_req_after", {31'b0, dmem_req}, 32'd0);
    check("rstw_busy_after", {31'b0, busy}, 32'd0);
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0000;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rstw_no_done", {31'b0, done}, 32'd0);
      check("rstw_idle_busy", {31'b0, busy}, 32'd0);
      @(posedge clock); #1;
    end

    // valid_in with neither read nor write starts nothing.
    valid_in = 1'b1; size = 2'b10; addr = 32'h10;
    @(posedge clock); #1;
    valid_in = 1'b0;
    check("nop_busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    check("nop_done", {31'b0, done}, 32'd0);

`ifdef MMIO_EN
    sb.push_back('{"mmio_sh", 32'h0, 1'b0});
    valid_in = 1'b1; mem_write = 1'b1; size = 2'b01; addr = 32'hFFFF_FC62; wdata = 32'h0000_1234;
    @(posedge clock); #1;
    valid_in = 1'b0; mem_write = 1'b0;
    @(posedge clock); #1;
    check("mmio_io_req", {31'b0, io_req}, 32'd1);
    check("mmio_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("mmio_io_we", {31'b0, io_we}, 32'd1);
    check("mmio_addr", io_addr, 32'hFFFF_FC60);
    check("mmio_be", {28'b0, io_be}, 32'h0000_000C);
    check("mmio_lanes", io_wdata, 32'h1234_1234);
    io_ack = 1'b1;
    @(posedge clock); #1;
    io_ack = 1'b0;
    check("mmio_done", {31'b0, done}, 32'd1);
    @(posedge clock); #1;
`endif

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
